// File: rtl/fetch_pkg.sv
// Shared constants and branch-counter helpers for the fetch stage.
package fetch_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;
    localparam logic [31:0] NOP = 32'h0;

    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } ctr_e;

    // Saturating step towards strongly-taken.
    function automatic ctr_e ctrInc(input ctr_e c);
        return (c == CTR_ST) ? CTR_ST : ctr_e'(2'(c) + 2'd1);
    endfunction

    // Saturating step towards strongly-not-taken.
    function automatic ctr_e ctrDec(input ctr_e c);
        return (c == CTR_SNT) ? CTR_SNT : ctr_e'(2'(c) - 2'd1);
    endfunction

endpackage

// File: rtl/fetch_bp_if.sv
// Fetch-stage bus: redirect/update inputs, imem port and decode-register outputs.
interface fetch_bp_if #(
    parameter int unsigned XLEN = fetch_pkg::XLEN_DEFAULT
);
    logic            stall;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            upd_en;
    logic [XLEN-1:0] upd_pc;
    logic            upd_taken;
    logic [XLEN-1:0] upd_target;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] instrD;
    logic [XLEN-1:0] pcplus4D;
    logic [XLEN-1:0] pred_targetD;
    logic            validD;
    logic            pred_takenD;
    logic [31:0]     mispred_cnt;

    modport master (
        output stall, redirect, redirect_pc, upd_en, upd_pc, upd_taken, upd_target, instr,
        input  pc, instrD, pcplus4D, pred_targetD, validD, pred_takenD, mispred_cnt
    );

    modport slave (
        input  stall, redirect, redirect_pc, upd_en, upd_pc, upd_taken, upd_target, instr,
        output pc, instrD, pcplus4D, pred_targetD, validD, pred_takenD, mispred_cnt
    );
endinterface

// File: rtl/btb.sv
// Direct-mapped branch target buffer with 2-bit counters; lookup is combinational,
// updates land at the clock edge so a same-cycle lookup sees pre-update state.
module btb
    import fetch_pkg::*;
#(
    parameter int unsigned XLEN        = XLEN_DEFAULT,
    parameter int unsigned BTB_ENTRIES = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-3:0] lookupWord,
    output logic            predTaken_c,
    output logic [XLEN-1:0] predTarget_c,
    input  logic            updEn,
    input  logic [XLEN-3:0] updWord,
    input  logic            updTaken,
    input  logic [XLEN-1:0] updTarget
);
    localparam int unsigned IDXW = $clog2(BTB_ENTRIES);
    localparam int unsigned TAGW = XLEN - 2 - IDXW;

    logic            entryValid  [BTB_ENTRIES];
    logic [TAGW-1:0] entryTag    [BTB_ENTRIES];
    logic [XLEN-1:0] entryTarget [BTB_ENTRIES];
    ctr_e            entryCtr    [BTB_ENTRIES];

    logic [IDXW-1:0] lookupIdx_c;
    logic [TAGW-1:0] lookupTag_c;
    logic [IDXW-1:0] updIdx_c;
    logic [TAGW-1:0] updTag_c;
    logic            updHit_c;

    assign lookupIdx_c = lookupWord[IDXW-1:0];
    assign lookupTag_c = lookupWord[XLEN-3:IDXW];
    assign updIdx_c    = updWord[IDXW-1:0];
    assign updTag_c    = updWord[XLEN-3:IDXW];
    assign updHit_c    = entryValid[updIdx_c] && (entryTag[updIdx_c] == updTag_c);

    // Prediction from the indexed entry: taken only on a tag hit with counter MSB set.
    always_comb begin
        predTaken_c  = 1'b0;
        predTarget_c = entryTarget[lookupIdx_c];
        if (entryValid[lookupIdx_c] && (entryTag[lookupIdx_c] == lookupTag_c)) begin
            predTaken_c = entryCtr[lookupIdx_c][1];
        end
    end

    // Train on hit, allocate on taken miss, ignore not-taken miss.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < int'(BTB_ENTRIES); i++) begin
                entryValid[i] <= 1'b0;
                entryCtr[i]   <= CTR_WNT;
            end
        end else if (updEn) begin
            if (updHit_c) begin
                entryCtr[updIdx_c] <= updTaken ? ctrInc(entryCtr[updIdx_c])
                                               : ctrDec(entryCtr[updIdx_c]);
                if (updTaken) begin
                    entryTarget[updIdx_c] <= updTarget;
                end
            end else if (updTaken) begin
                entryValid[updIdx_c]  <= 1'b1;
                entryTag[updIdx_c]    <= updTag_c;
                entryTarget[updIdx_c] <= updTarget;
                entryCtr[updIdx_c]    <= CTR_WT;
            end
        end
    end

endmodule

// File: rtl/fetch_bp.sv
// Fetch stage: pc register, next-pc selection, fetch/decode register and redirect counter.
module fetch_bp
    import fetch_pkg::*;
#(
    parameter int unsigned     XLEN        = XLEN_DEFAULT,
    parameter int unsigned     BTB_ENTRIES = 16,
    parameter logic [XLEN-1:0] RESET_PC    = '0
) (
    input logic       clk,
    input logic       reset,
    fetch_bp_if.slave bus
);
    logic            predTaken_c;
    logic [XLEN-1:0] predTarget_c;
    logic [XLEN-1:0] pcPlus4_c;
    logic [XLEN-1:0] nextPc_c;

    btb #(
        .XLEN        (XLEN),
        .BTB_ENTRIES (BTB_ENTRIES)
    ) uBtb (
        .clk          (clk),
        .reset        (reset),
        .lookupWord   (bus.pc[XLEN-1:2]),
        .predTaken_c  (predTaken_c),
        .predTarget_c (predTarget_c),
        .updEn        (bus.upd_en),
        .updWord      (bus.upd_pc[XLEN-1:2]),
        .updTaken     (bus.upd_taken),
        .updTarget    (bus.upd_target)
    );

    assign pcPlus4_c = bus.pc + XLEN'(4);
    assign nextPc_c  = predTaken_c ? predTarget_c : pcPlus4_c;

    // Fetch address: redirect beats stall, otherwise follow the prediction.
    always_ff @(posedge clk) begin
        if (!reset) begin
            bus.pc <= RESET_PC;
        end else if (bus.redirect) begin
            bus.pc <= bus.redirect_pc;
        end else if (!bus.stall) begin
            bus.pc <= nextPc_c;
        end
    end

    // Fetch/decode register: a redirect squashes the slot even while stalled.
    always_ff @(posedge clk) begin
        if (!reset || bus.redirect) begin
            bus.instrD       <= XLEN'(NOP);
            bus.validD       <= 1'b0;
            bus.pred_takenD  <= 1'b0;
        end else if (!bus.stall) begin
            bus.instrD       <= bus.instr;
            bus.validD       <= 1'b1;
            bus.pred_takenD  <= predTaken_c;
        end
    end

    // Sideband of the decode slot; cleared only by reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            bus.pcplus4D     <= '0;
            bus.pred_targetD <= '0;
        end else if (!bus.redirect && !bus.stall) begin
            bus.pcplus4D     <= pcPlus4_c;
            bus.pred_targetD <= nextPc_c;
        end
    end

    // Redirect counter, wraps naturally at 2^32.
    always_ff @(posedge clk) begin
        if (!reset) begin
            bus.mispred_cnt <= '0;
        end else if (bus.redirect) begin
            bus.mispred_cnt <= bus.mispred_cnt + 32'd1;
        end
    end

endmodule
